// File: rtl/legv8_pkg.sv
// legv8_pkg: opcode constants, the NOP encoding and condition codes shared by the LEGv8 pipeline
package legv8_pkg;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'hB4;
    localparam logic [7:0]  OP_CBNZ  = 8'hB5;
    localparam logic [7:0]  OP_BCOND = 8'h54;
    localparam logic [31:0] NOP_WORD = 32'hD503201F;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_HS, CC_LO, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_t;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: evaluates a 4-bit condition code against the NZCV flags
module branch_cond_eval
    import legv8_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       cond_true
);

    // AL and NV both mean "always" in this pipeline
    always_comb begin
        cond_true = 1'b1;
        case (cond_t'(cond))
            CC_EQ: cond_true = z;
            CC_NE: cond_true = !z;
            CC_HS: cond_true = c;
            CC_LO: cond_true = !c;
            CC_MI: cond_true = n;
            CC_PL: cond_true = !n;
            CC_VS: cond_true = v;
            CC_VC: cond_true = !v;
            CC_HI: cond_true = c & !z;
            CC_LS: cond_true = !(c & !z);
            CC_GE: cond_true = n == v;
            CC_LT: cond_true = n != v;
            CC_GT: cond_true = !z & (n == v);
            CC_LE: cond_true = !(!z & (n == v));
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/if_id_redirect.sv
// if_id_redirect: IF/ID register with ID-stage branch resolution and wrong-path squash
module if_id_redirect
    import legv8_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = legv8_pkg::NOP_WORD,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      pc_cur,
    input  logic [31:0]      instr_in,
    input  logic             stall,
    input  logic             rt_zero,
    input  logic             flag_n,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_v,
    output logic [63:0]      pc_target,
    output logic             pc_src,
    output logic             pc_en,
    output logic [63:0]      id_pc,
    output logic [31:0]      id_instr,
    output logic             id_valid,
    output logic [CNT_W-1:0] taken_cnt
);

    logic is_b, is_cbz, is_cbnz, is_bcond, bcond_true, taken;

    branch_cond_eval u_cond (
        .cond      (id_instr[3:0]),
        .n         (flag_n),
        .z         (flag_z),
        .c         (flag_c),
        .v         (flag_v),
        .cond_true (bcond_true)
    );

    // decode the held instruction, resolve the branch and form its target
    always_comb begin
        is_b      = id_instr[31:26] == OP_B;
        is_cbz    = id_instr[31:24] == OP_CBZ;
        is_cbnz   = id_instr[31:24] == OP_CBNZ;
        is_bcond  = id_instr[31:24] == OP_BCOND && !id_instr[4];
        pc_target = id_pc + (is_b ? {{36{id_instr[25]}}, id_instr[25:0], 2'b00}
                                  : {{43{id_instr[23]}}, id_instr[23:5], 2'b00});
        taken     = id_valid & (is_b | (is_cbz & rt_zero) | (is_cbnz & !rt_zero) | (is_bcond & bcond_true));
        pc_src    = taken & !stall;
        pc_en     = !stall;
    end

    // IF/ID register: stall holds, a redirect squashes the fetched wrong-path word
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_instr <= NOP_WORD;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_instr <= pc_src ? NOP_WORD : instr_in;
            id_pc    <= pc_cur;
            id_valid <= !pc_src;
        end
    end

    // saturating count of redirects actually issued
    always_ff @(posedge clk) begin
        if (!reset)
            taken_cnt <= '0;
        else if (pc_src && !(&taken_cnt))
            taken_cnt <= taken_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_if_id_redirect.sv
// tb_if_id_redirect: scoreboard bench for the IF/ID register and branch redirect
module tb_if_id_redirect;

    localparam logic [31:0] NOP  = 32'hD503201F;
    localparam logic [31:0] ADD  = 32'h8B020020;
    localparam logic [31:0] BP16 = 32'h14000004;
    localparam logic [31:0] BM4  = 32'h17FFFFFF;
    localparam logic [31:0] CBZM = 32'hB4FFFFC0;
    localparam logic [31:0] CBNZ = 32'hB5000040;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, rt_zero = 1'b0;
    logic        flag_n = 1'b0, flag_z = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
    logic [63:0] pc_cur = '0;
    logic [31:0] instr_in = '0;
    logic [63:0] pc_target, id_pc;
    logic        pc_src, pc_en, id_valid;
    logic [31:0] id_instr;
    logic [31:0] taken_cnt;

    if_id_redirect dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .instr_in(instr_in),
        .stall(stall), .rt_zero(rt_zero),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .pc_target(pc_target), .pc_src(pc_src), .pc_en(pc_en),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic        en;
        logic [63:0] target;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0, n_errors = 0;
    logic        known = 1'b0;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic        m_src;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] cc, input logic n, z, c, v);
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !(c && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return !(!z && n == v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic r, s, rz, input logic [3:0] nzcv, input logic [63:0] pc, input logic [31:0] ins);
        exp_t e, o;
        longint off;
        logic hit;
        @(negedge clk);
        reset = r; stall = s; rt_zero = rz; pc_cur = pc; instr_in = ins;
        {flag_n, flag_z, flag_c, flag_v} = nzcv;
        if (m_instr[31:26] == 6'b000101) off = longint'($signed(m_instr[25:0]));
        else off = longint'($signed(m_instr[23:5]));
        hit = (m_instr[31:26] == 6'b000101)
            || (m_instr[31:24] == 8'hB4 && rz)
            || (m_instr[31:24] == 8'hB5 && !rz)
            || (m_instr[31:24] == 8'h54 && !m_instr[4] && ref_cond(m_instr[3:0], nzcv[3], nzcv[2], nzcv[1], nzcv[0]));
        m_src    = m_valid && hit && !s;
        e.src    = m_src;
        e.en     = !s;
        e.target = m_pc + 64'(off * 4);
        e.pc     = m_pc;
        e.instr  = m_instr;
        e.valid  = m_valid;
        e.cnt    = m_cnt;
        if (known) sb.push_back(e);
        #1;
        if (sb.size() > 0) begin
            o = sb.pop_front();
            chk("pc_src", 64'(pc_src), 64'(o.src));
            chk("pc_en", 64'(pc_en), 64'(o.en));
            if (o.src) chk("pc_target", pc_target, o.target);
            chk("id_pc", id_pc, o.pc);
            chk("id_instr", 64'(id_instr), 64'(o.instr));
            chk("id_valid", 64'(id_valid), 64'(o.valid));
            chk("taken_cnt", 64'(taken_cnt), 64'(o.cnt));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            known = 1'b1; m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_cnt = '0;
        end else if (!stall) begin
            if (m_src && m_cnt != '1) m_cnt++;
            m_instr = m_src ? NOP : instr_in;
            m_valid = !m_src;
            m_pc    = pc_cur;
        end
    endtask

    task automatic step(input logic [63:0] pc, input logic [31:0] ins);
        drive(1'b1, 1'b0, 1'b0, 4'h0, pc, ins);
        tick();
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'h0, 64'h0, ADD); tick();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 64'h0, ADD); tick();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h0, ADD);
        chk("rst_valid", 64'(id_valid), 64'h0);
        chk("rst_instr", 64'(id_instr), 64'hD503201F);
        chk("rst_cnt", 64'(taken_cnt), 64'h0);
        chk("rst_pc_en", 64'(pc_en), 64'h1);
        chk("rst_pc_src", 64'(pc_src), 64'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h40, BP16);
        chk("load_pc", id_pc, 64'h0);
        chk("load_valid", 64'(id_valid), 64'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h44, ADD);
        chk("b_src", 64'(pc_src), 64'h1);
        chk("b_target", pc_target, 64'h50);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h50, ADD);
        chk("b_bubble", 64'(id_valid), 64'h0);
        chk("b_nop", 64'(id_instr), 64'hD503201F);
        chk("b_cnt", 64'(taken_cnt), 64'h1);
        tick();
        step(64'h0, BM4);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h4, ADD);
        chk("wrap_target", pc_target, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'h0, 64'h100, CBZM); tick();
        drive(1'b1, 1'b0, 1'b1, 4'h0, 64'h104, ADD);
        chk("cbz_target", pc_target, 64'hF8);
        chk("cbz_src", 64'(pc_src), 64'h1);
        tick();
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                step(64'h200, 32'h54000040 | 32'(c));
                drive(1'b1, 1'b0, 1'b0, 4'(f), 64'h204, ADD);
                if (c == 10 && f == 9) chk("bge_nv11", 64'(pc_src), 64'h1);
                if (c == 10 && f == 8) chk("bge_n1v0", 64'(pc_src), 64'h0);
                tick();
            end
        end
        step(64'h300, CBNZ);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h0, 64'h304, ADD);
            chk("stall_src", 64'(pc_src), 64'h0);
            chk("stall_en", 64'(pc_en), 64'h0);
            chk("stall_pc", id_pc, 64'h300);
            chk("stall_instr", 64'(id_instr), 64'(CBNZ));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h304, ADD);
        chk("unstall_src", 64'(pc_src), 64'h1);
        chk("cbnz_target", pc_target, 64'h308);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h308, ADD);
        chk("unstall_once", 64'(pc_src), 64'h0);
        chk("unstall_bubble", 64'(id_valid), 64'h0);
        tick();
        step(64'h400, BP16);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 64'h404, ADD);
        chk("rflush_src", 64'(pc_src), 64'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 64'h408, ADD);
        chk("rflush_cnt", 64'(taken_cnt), 64'h0);
        chk("rflush_valid", 64'(id_valid), 64'h0);
        chk("rflush_pc", id_pc, 64'h0);
        chk("rflush_instr", 64'(id_instr), 64'hD503201F);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_redirect.md
Name: if_id_redirect

Overview:
- IF/ID pipeline register paired with ID-stage branch resolution for the 64-bit LEGv8 pipelined CPU.
- Consumes the program counter value and the fetched instruction. Produces the `in`/`PCsrc`/`en` controls that steer the program counter.
- Resolves B, CBZ, CBNZ and B.cond in ID, computes the branch target, and squashes the wrong-path instruction after a taken branch.
- Sits between the program counter/instruction memory and the decode stage.

Parameters:
- NOP_WORD, 32'hD503201F, encoding inserted on reset and flush.
- CNT_W, 32, width of the taken-branch performance counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- pc_cur  input  64  current program counter value (address of the instruction being fetched).
- instr_in  input  32  instruction memory data at pc_cur.
- stall  input  1  hazard-unit stall request.
- rt_zero  input  1  ID-stage register read of Rt equals zero (for CBZ/CBNZ).
- flag_n, flag_z, flag_c, flag_v  input  1 each  committed condition flags.
- pc_target  output  64  branch target, drives the program counter's next-value input.
- pc_src  output  1  select pc_target over PC+4.
- pc_en  output  1  program counter write enable.
- id_pc  output  64  PC of the instruction held in ID.
- id_instr  output  32  instruction held in ID.
- id_valid  output  1  ID holds a real (non-bubble) instruction.
- taken_cnt  output  CNT_W  count of taken branches.

Behaviour:
- Reset (reset==0 at posedge):
  - id_instr<=NOP_WORD, id_pc<=0, id_valid<=0, taken_cnt<=0.
  - pc_src=0 and pc_en=1 combinationally whenever id_valid==0 and stall==0.
- IF/ID register update, priority reset > stall > flush > load:
  - stall=1: hold all of id_pc, id_instr, id_valid.
  - flush (taken branch this cycle, no stall): id_instr<=NOP_WORD, id_valid<=0, id_pc<=pc_cur.
  - load: id_instr<=instr_in, id_pc<=pc_cur, id_valid<=1.
- Decode, combinational from id_instr:
  - B: [31:26]==6'b000101, imm26=[25:0].
  - CBZ: [31:24]==8'hB4. CBNZ: [31:24]==8'hB5. Both use imm19=[23:5].
  - B.cond: [31:24]==8'h54 and [4]==0, cond=[3:0], imm19=[23:5].
- Target: pc_target = id_pc + (sign_extend(imm) << 2), computed in 64 bits with wrap-around modulo 2^64. It is driven at all times (don't-care when pc_src=0).
- Branch-taken conditions:
  - B: always.
  - CBZ: rt_zero. CBNZ: !rt_zero.
  - B.cond codes 0..F: EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)); AL 1; NV 1.
- taken = id_valid & branch_hit & cond_true.
- Outputs to the program counter:
  - pc_src = taken & !stall.
  - pc_en = !stall.
- Latency: a branch redirects the program counter at the posedge ending its ID cycle. Exactly one wrong-path instruction is squashed (one-cycle penalty).
- Stall with taken branch: stall wins. pc_src=0, pc_en=0, IF/ID holds, and the branch re-resolves next cycle using the flags and rt_zero sampled then.
- Bubble in ID (id_valid=0) never redirects, even if the NOP pattern matched.
- Back-to-back branches: the second branch is in the squashed slot, so it never resolves.
- taken_cnt increments by 1 on each cycle with pc_src=1 and saturates at all-ones.
- Reset asserted mid-stall or mid-flush: reset values apply at that edge, and any pending redirect is discarded.

Decomposition:
- Shared package `legv8_pkg`:
  - opcode constants OP_B, OP_CBZ, OP_CBNZ, OP_BCOND.
  - NOP_WORD.
  - the 4-bit condition-code enumeration.
- One natural sub-module: `branch_cond_eval` (cond[3:0], N, Z, C, V -> cond_true), purely combinational and reusable by the flags/execute logic.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release. Then id_valid=0, id_instr=D503201F, taken_cnt=0, pc_en=1, pc_src=0. The next edge loads pc_cur=0, instr_in=8B020020 -> id_pc=0, id_valid=1.
- Unconditional B:
  - Setup: id_pc=0x40, id_instr=0x14000004 (B +16).
  - Check: pc_src=1, pc_target=0x50.
  - Next edge: id_valid=0, id_instr=NOP, taken_cnt=1.
- Negative offset with wrap:
  - Setup: id_pc=0x0, B imm26=0x3FFFFFF.
  - Check: pc_target=0xFFFF_FFFF_FFFF_FFFC.
  - Setup: CBZ imm19=0x7FFFE, rt_zero=1, id_pc=0x100.
  - Check: pc_target=0xF8, pc_src=1.
- B.cond sweep: for each of the 16 cond codes and all 16 NZCV combinations, pc_src matches the reference condition table. Check B.GE with N=1, V=1 -> taken, and with N=1, V=0 -> not taken.
- Stall vs branch:
  - Setup: taken CBNZ in ID (rt_zero=0) with stall=1 for 3 cycles.
  - Check: pc_src=0, pc_en=0, ID contents unchanged. Drop stall -> pc_src=1 for exactly one cycle, then a bubble.
- Reset during flush: assert reset on the cycle with pc_src=1. Next edge gives reset values and taken_cnt=0, with no extra increment.
